// File: rtl/tq_premuat_ctrl_if.sv
// tq_premuat_ctrl_if
// Bundles the request/handshake and datapath-control signals of the
// premutation row scheduler.
//   start, tu_size, inverse, in_valid : request side, into the scheduler
//   rd_en                             : pop strobe to the input row buffer
//   busy, done                        : TU status
//   o_valid, o_row, o_last, o_inverse,
//   o_en8, o_en16, o_en32             : per-row control aligned with row data
//   stall_cnt                         : only when TQ_PREMUAT_CTRL_STALL_CNT_EN
//                                       is defined
// Modports: master = requester/consumer side, slave = scheduler.
interface tq_premuat_ctrl_if;
  logic       start;
  logic [1:0] tu_size;
  logic       inverse;
  logic       in_valid;
  logic       rd_en;
  logic       busy;
  logic       done;
  logic       o_valid;
  logic [4:0] o_row;
  logic       o_last;
  logic       o_inverse;
  logic       o_en8;
  logic       o_en16;
  logic       o_en32;
`ifdef TQ_PREMUAT_CTRL_STALL_CNT_EN
  logic [7:0] stall_cnt;
`endif

  modport master (
`ifdef TQ_PREMUAT_CTRL_STALL_CNT_EN
    input  stall_cnt,
`endif
    output start, tu_size, inverse, in_valid,
    input  rd_en, busy, done, o_valid, o_row, o_last, o_inverse,
           o_en8, o_en16, o_en32
  );

  modport slave (
`ifdef TQ_PREMUAT_CTRL_STALL_CNT_EN
    output stall_cnt,
`endif
    input  start, tu_size, inverse, in_valid,
    output rd_en, busy, done, o_valid, o_row, o_last, o_inverse,
           o_en8, o_en16, o_en32
  );
endinterface

// File: rtl/tq_premuat_ctrl.sv
// tq_premuat_ctrl
// Row scheduler for the 8/16/32-point premutation datapath. A start in IDLE
// latches TU size/direction; rows 0..N-1 (N = 4 << tu_size) are then popped
// from the input buffer one per cycle whenever a row is available. The
// per-row control tuple travels through a PIPE_DEPTH-stage shift pipeline so
// it reaches the premutation stages together with the row data. done pulses
// once the last row's control has left the pipeline.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (aborts a TU without done)
//   bus  : tq_premuat_ctrl_if.slave (request, rd_en, status, o_* controls)
// Parameter:
//   PIPE_DEPTH : cycles from rd_en to row arrival at the datapath (1..8)
// Optional build macro:
//   TQ_PREMUAT_CTRL_STALL_CNT_EN : adds bus.stall_cnt, a saturating count of
//   ROW cycles lost to an empty input buffer.
module tq_premuat_ctrl #(
  parameter int PIPE_DEPTH = 2
) (
  input logic              clk,
  input logic              rst,
  tq_premuat_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROW   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] row;
    logic       last;
    logic       inverse;
    logic       en8;
    logic       en16;
    logic       en32;
  } pipe_t;

  state_t     state_r;
  state_t     state_next_s;
  logic [1:0] size_r;
  logic       inverse_r;
  logic [4:0] row_r;
  logic       busy_r;
  logic       done_r;
  logic       rd_en_s;
  logic       start_acc_s;
  logic [4:0] last_row_s;
  logic       issue_last_s;
  pipe_t      issue_s;
  pipe_t      out_s;
  pipe_t      pipe_r [PIPE_DEPTH];

  assign start_acc_s  = (state_r == IDLE) && bus.start;
  assign issue_last_s = (row_r == last_row_s);

  // Index of the final row for the latched TU size.
  always_comb begin
    last_row_s = 5'd31;
    case (size_r)
      2'd0:    last_row_s = 5'd3;
      2'd1:    last_row_s = 5'd7;
      2'd2:    last_row_s = 5'd15;
      default: last_row_s = 5'd31;
    endcase
  end

  // Next-state decode and the combinational row pop strobe.
  always_comb begin
    state_next_s = state_r;
    rd_en_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_next_s = ROW;
        end else begin
          state_next_s = IDLE;
        end
      end
      ROW: begin
        // rst gates the pop so no row is consumed on an aborting cycle.
        if (bus.in_valid && !rst) begin
          rd_en_s = 1'b1;
          if (issue_last_s) begin
            state_next_s = DRAIN;
          end else begin
            state_next_s = ROW;
          end
        end else begin
          state_next_s = ROW;
        end
      end
      DRAIN: begin
        if (out_s.valid && out_s.last) begin
          state_next_s = DONE;
        end else begin
          state_next_s = DRAIN;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Issue-stage tuple; every field is zero on a bubble.
  always_comb begin
    issue_s = '0;
    if (rd_en_s) begin
      issue_s.valid   = 1'b1;
      issue_s.row     = row_r;
      issue_s.last    = issue_last_s;
      issue_s.inverse = inverse_r;
      issue_s.en8     = (size_r != 2'd0);
      issue_s.en16    = size_r[1];
      issue_s.en32    = (size_r == 2'd3);
    end else begin
      issue_s = '0;
    end
  end

  // FSM state, latched TU config, row counter and registered status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      size_r    <= 2'd0;
      inverse_r <= 1'b0;
      row_r     <= 5'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != IDLE);
      done_r  <= (state_next_s == DONE);
      if (start_acc_s) begin
        size_r    <= bus.tu_size;
        inverse_r <= bus.inverse;
        row_r     <= 5'd0;
      end else if (rd_en_s && !issue_last_s) begin
        // Counter parks on N-1 after the last issue so it never wraps.
        row_r <= row_r + 5'd1;
      end else begin
        row_r <= row_r;
      end
    end
  end

  // Free-running control delay line; bubbles shift through unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        pipe_r[i] <= '0;
      end
    end else begin
      pipe_r[0] <= issue_s;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  assign out_s         = pipe_r[PIPE_DEPTH-1];
  assign bus.rd_en     = rd_en_s;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.o_valid   = out_s.valid;
  assign bus.o_row     = out_s.row;
  assign bus.o_last    = out_s.last;
  assign bus.o_inverse = out_s.inverse;
  assign bus.o_en8     = out_s.en8;
  assign bus.o_en16    = out_s.en16;
  assign bus.o_en32    = out_s.en32;

`ifdef TQ_PREMUAT_CTRL_STALL_CNT_EN
  logic [7:0] stall_cnt_r;

  // Saturating count of ROW cycles with no input row available.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= 8'd0;
    end else if (start_acc_s) begin
      stall_cnt_r <= 8'd0;
    end else if ((state_r == ROW) && !bus.in_valid && (stall_cnt_r != 8'hFF)) begin
      stall_cnt_r <= stall_cnt_r + 8'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign bus.stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_tq_premuat_ctrl.sv
// tb_tq_premuat_ctrl
// Table-driven bench for tq_premuat_ctrl (PIPE_DEPTH = 2). Each table record
// describes one TU (size, direction, in_valid gaps, stray start pulses,
// optional mid-TU reset) with its expected row count, enables and done cycle.
// Expected per-row controls are pushed to a scoreboard queue when a row issue
// is expected and popped when the delayed output is due.
module tb_tq_premuat_ctrl;
  localparam int PIPE_DEPTH = 2;
  localparam int MAX_CYC    = 200;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;

  tq_premuat_ctrl_if bus ();

  tq_premuat_ctrl #(.PIPE_DEPTH(PIPE_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  sz;
    logic        inv;
    logic [63:0] stall_mask;
    logic [63:0] start_mask;
    bit          start_on_done;
    int          abort_at;
    int          exp_rows;
    logic        e8;
    logic        e16;
    logic        e32;
    int          exp_done;
    int          exp_stall;
  } vec_t;

  typedef struct {
    int         tgt;
    logic [4:0] row;
    logic       last;
  } exp_t;

  exp_t q[$];
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_o_valid"}, 32'(bus.o_valid), 32'd0);
    chk({tag, "_o_row"}, 32'(bus.o_row), 32'd0);
    chk({tag, "_o_last"}, 32'(bus.o_last), 32'd0);
    chk({tag, "_o_inverse"}, 32'(bus.o_inverse), 32'd0);
    chk({tag, "_o_en"}, 32'({bus.o_en8, bus.o_en16, bus.o_en32}), 32'd0);
  endtask

  task automatic run_tu(input vec_t v);
    int   c;
    int   n;
    int   issued;
    int   done_exp;
    int   done_seen;
    int   rd_seen;
    bit   finished;
    logic exp_rd;
    exp_t e;

    n = 4 << v.sz;
    // Cycle 0: the request, presented in the first IDLE cycle.
    bus.start    = 1'b1;
    bus.tu_size  = v.sz;
    bus.inverse  = v.inv;
    bus.in_valid = 1'b1;
    rst          = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_done", 32'(bus.done), 32'd0);
    chk("idle_rd_en", 32'(bus.rd_en), 32'd0);
    chk_outputs_zero("idle");
    @(posedge clk); #1;

    issued = 0; done_exp = -1; done_seen = -1; rd_seen = 0; finished = 1'b0; c = 1;
    while (!finished) begin
      // Config inputs deliberately differ from the latched values from now on.
      bus.tu_size  = ~v.sz;
      bus.inverse  = ~v.inv;
      bus.start    = ((c < 64) ? v.start_mask[c] : 1'b0) | (v.start_on_done && (c == done_exp));
      bus.in_valid = (c < 64) ? ~v.stall_mask[c] : 1'b1;
      rst          = (c == v.abort_at);
      exp_rd       = (issued < n) && bus.in_valid && !rst;
      @(negedge clk);
      chk("rd_en", 32'(bus.rd_en), 32'(exp_rd));
      if (bus.rd_en) rd_seen++;
      if (exp_rd) begin
        e.tgt  = c + PIPE_DEPTH;
        e.row  = 5'(issued);
        e.last = (issued == n - 1);
        q.push_back(e);
        issued++;
      end
      if ((q.size() > 0) && (q[0].tgt == c)) begin
        e = q.pop_front();
        chk("o_valid", 32'(bus.o_valid), 32'd1);
        chk("o_row", 32'(bus.o_row), 32'(e.row));
        chk("o_last", 32'(bus.o_last), 32'(e.last));
        chk("o_inverse", 32'(bus.o_inverse), 32'(v.inv));
        chk("o_en8", 32'(bus.o_en8), 32'(v.e8));
        chk("o_en16", 32'(bus.o_en16), 32'(v.e16));
        chk("o_en32", 32'(bus.o_en32), 32'(v.e32));
        if (e.last) done_exp = c + 1;
      end else begin
        chk_outputs_zero("bubble");
      end
      chk("done", 32'(bus.done), 32'(c == done_exp));
      chk("busy", 32'(bus.busy), 32'd1);
      if (bus.done && (done_seen < 0)) done_seen = c;
`ifdef TQ_PREMUAT_CTRL_STALL_CNT_EN
      if ((c == done_exp) && (v.abort_at == 0)) chk("stall_cnt", 32'(bus.stall_cnt), 32'(v.exp_stall));
`endif
      if (c >= MAX_CYC) begin
        n_fail++;
        $display("FAIL timeout: got no done by cycle %0d expected done by %0d", c, MAX_CYC);
      end
      if ((c == done_exp) || (c == v.abort_at) || (c >= MAX_CYC)) finished = 1'b1;
      @(posedge clk); #1;
      c++;
    end

    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    if (v.abort_at > 0) begin
      // After the reset edge everything is quiet and in-flight rows vanish.
      rst = 1'b0;
      q.delete();
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk("abort_rd_en", 32'(bus.rd_en), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk_outputs_zero("abort");
        @(posedge clk); #1;
      end
    end else begin
      chk("rows_issued", 32'(rd_seen), 32'(v.exp_rows));
      chk("done_cycle", 32'(done_seen), 32'(v.exp_done));
      chk("scoreboard_empty", 32'(q.size()), 32'd0);
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    // sz inv stall_mask start_mask on_done abort rows e8 e16 e32 done stall
    vecs[0] = '{2'd1, 1'b1, 64'h0,  64'h0,  1'b0, 0,  8,  1'b1, 1'b0, 1'b0, 11, 0};
    vecs[1] = '{2'd0, 1'b0, 64'h0,  64'h0,  1'b0, 0,  4,  1'b0, 1'b0, 1'b0, 7,  0};
    vecs[2] = '{2'd3, 1'b1, 64'h60, 64'h0,  1'b0, 0,  32, 1'b1, 1'b1, 1'b1, 37, 2};
    vecs[3] = '{2'd1, 1'b0, 64'h0,  64'h28, 1'b1, 0,  8,  1'b1, 1'b0, 1'b0, 11, 0};
    vecs[4] = '{2'd2, 1'b1, 64'h0,  64'h0,  1'b0, 11, 16, 1'b1, 1'b1, 1'b0, 19, 0};
    vecs[5] = '{2'd2, 1'b1, 64'h0,  64'h0,  1'b0, 0,  16, 1'b1, 1'b1, 1'b0, 19, 0};
    vecs[6] = '{2'd0, 1'b1, 64'h4,  64'h0,  1'b0, 0,  4,  1'b0, 1'b0, 1'b0, 8,  1};

    rst = 1'b1;
    bus.start = 1'b0; bus.tu_size = 2'd0; bus.inverse = 1'b0; bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_rd_en", 32'(bus.rd_en), 32'd0);
    chk_outputs_zero("reset");
`ifdef TQ_PREMUAT_CTRL_STALL_CNT_EN
    chk("reset_stall_cnt", 32'(bus.stall_cnt), 32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Records run back-to-back: each start lands on the first IDLE cycle.
    for (int i = 0; i < 7; i++) begin
      run_tu(vecs[i]);
    end

    @(negedge clk);
    chk("final_busy", 32'(bus.busy), 32'd0);
    chk("final_done", 32'(bus.done), 32'd0);
    chk_outputs_zero("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
